matmul_sequencer: RTL and testbench

- Control FSM for the matmul accelerator datapath.
- Accepts a start command decoded from the CONTROL register and clears the PE array.
- Streams K operand slices from the OPERAND_A/OPERAND_B buffers into the skewed systolic array, then writes the N result rows into the selected scratchpad (SP) target, with optional bias accumulation.
- Raises busy/done status for the FLAGS register; the golden checker compares SP contents after done.

---
 rtl/matmul_sequencer.sv | 156 +++++++++++++++
 tb/tb_matmul_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// Control FSM for the matmul accelerator: clears the PE array, streams K skewed operand
// slices, then writes N result rows (optionally bias-accumulated) into a scratchpad target.
module matmul_sequencer #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned BUS_WIDTH   = 32,
    parameter int unsigned MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
    parameter int unsigned SP_NTARGETS = 4,
    localparam int unsigned DIM_W      = $clog2(MAX_DIM),
    localparam int unsigned TGT_W      = $clog2(SP_NTARGETS),
    localparam int unsigned FEED_W     = $clog2(2 * MAX_DIM + MAX_DIM)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               bias_en_i,
    input  logic [DIM_W-1:0]   dim_n_i,
    input  logic [DIM_W-1:0]   dim_k_i,
    input  logic [DIM_W-1:0]   dim_m_i,
    input  logic [TGT_W-1:0]   write_target_i,
    input  logic [TGT_W-1:0]   read_target_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pe_clear_o,
    output logic               pe_valid_o,
    output logic [FEED_W-1:0]  feed_k_o,
    output logic               feed_zero_o,
    output logic               sp_rd_en_o,
    output logic               sp_wr_en_o,
    output logic [TGT_W+DIM_W-1:0] sp_addr_o,
    output logic               add_bias_o
);

    typedef enum logic [2:0] {StIdle, StClear, StFeed, StSettle, StWb, StDone} state_e;

    state_e              r_state, w_state_next;
    logic [FEED_W-1:0]   r_t, w_t_next;
    logic [DIM_W-1:0]    r_row, w_row_next;
    logic                r_phase, w_phase_next;

    // Dimensions are held in their minus-one encoding; K/N/M = r_dk/r_dn/r_dm + 1.
    logic [DIM_W-1:0]    r_dn, r_dk, r_dm;
    logic                r_bias;
    logic [TGT_W-1:0]    r_wt, r_rt;

    logic [FEED_W-1:0]   w_feed_last;
    logic                w_feed_zero;
    logic                w_start_accept;

    // Last feed step is K+N+M-3, which equals the sum of the minus-one encodings.
    assign w_feed_last    = FEED_W'(r_dk) + FEED_W'(r_dn) + FEED_W'(r_dm);
    assign w_feed_zero    = (r_t > FEED_W'(r_dk));
    assign w_start_accept = (r_state == StIdle) && start_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_t     <= '0;
            r_row   <= '0;
            r_phase <= 1'b0;
            r_dn    <= '0;
            r_dk    <= '0;
            r_dm    <= '0;
            r_bias  <= 1'b0;
            r_wt    <= '0;
            r_rt    <= '0;
        end else begin
            r_state <= w_state_next;
            r_t     <= w_t_next;
            r_row   <= w_row_next;
            r_phase <= w_phase_next;
            if (w_start_accept) begin
                r_dn   <= dim_n_i;
                r_dk   <= dim_k_i;
                r_dm   <= dim_m_i;
                r_bias <= bias_en_i;
                r_wt   <= write_target_i;
                r_rt   <= read_target_i;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_t_next     = r_t;
        w_row_next   = r_row;
        w_phase_next = r_phase;
        unique case (r_state)
            StIdle: begin
                if (start_i) w_state_next = StClear;
            end
            StClear: begin
                w_state_next = StFeed;
                w_t_next     = '0;
            end
            StFeed: begin
                if (r_t == w_feed_last) w_state_next = StSettle;
                else                    w_t_next     = r_t + 1'b1;
            end
            StSettle: begin
                w_state_next = StWb;
                w_row_next   = '0;
                w_phase_next = 1'b0;
            end
            StWb: begin
                // With bias each row takes a read phase followed by a write phase.
                if (r_bias && !r_phase) begin
                    w_phase_next = 1'b1;
                end else begin
                    w_phase_next = 1'b0;
                    if (r_row == r_dn) w_state_next = StDone;
                    else               w_row_next   = r_row + 1'b1;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_comb begin
        busy_o      = (r_state != StIdle);
        done_o      = 1'b0;
        pe_clear_o  = 1'b0;
        pe_valid_o  = 1'b0;
        feed_k_o    = '0;
        feed_zero_o = 1'b0;
        sp_rd_en_o  = 1'b0;
        sp_wr_en_o  = 1'b0;
        sp_addr_o   = '0;
        add_bias_o  = 1'b0;
        unique case (r_state)
            StClear: pe_clear_o = 1'b1;
            StFeed: begin
                pe_valid_o  = 1'b1;
                feed_k_o    = r_t;
                feed_zero_o = w_feed_zero;
            end
            StWb: begin
                if (r_bias && !r_phase) begin
                    sp_rd_en_o = 1'b1;
                    sp_addr_o  = {r_rt, r_row};
                end else begin
                    sp_wr_en_o = 1'b1;
                    sp_addr_o  = {r_wt, r_row};
                    add_bias_o = r_bias;
                end
            end
            StDone: done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: table-driven timing vectors, start/reset corner cases, and a
// behavioural skewed-array + scratchpad model for golden matrix checks.
module tb_matmul_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       start_i = 1'b0;
    logic       bias_en_i = 1'b0;
    logic [1:0] dim_n_i = '0, dim_k_i = '0, dim_m_i = '0;
    logic [1:0] write_target_i = '0, read_target_i = '0;
    logic       busy_o, done_o, pe_clear_o, pe_valid_o, feed_zero_o;
    logic       sp_rd_en_o, sp_wr_en_o, add_bias_o;
    logic [3:0] feed_k_o, sp_addr_o;

    always #5 clk_i = ~clk_i;

    matmul_sequencer u_dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .bias_en_i      (bias_en_i),
        .dim_n_i        (dim_n_i),
        .dim_k_i        (dim_k_i),
        .dim_m_i        (dim_m_i),
        .write_target_i (write_target_i),
        .read_target_i  (read_target_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .pe_clear_o     (pe_clear_o),
        .pe_valid_o     (pe_valid_o),
        .feed_k_o       (feed_k_o),
        .feed_zero_o    (feed_zero_o),
        .sp_rd_en_o     (sp_rd_en_o),
        .sp_wr_en_o     (sp_wr_en_o),
        .sp_addr_o      (sp_addr_o),
        .add_bias_o     (add_bias_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int all_out();
        return int'({busy_o, done_o, pe_clear_o, pe_valid_o, feed_k_o, feed_zero_o,
                     sp_rd_en_o, sp_wr_en_o, sp_addr_o, add_bias_o});
    endfunction

    // Datapath model: operand buffers, skewed PE array, scratchpad with 1-cycle read.
    int   a_buf[4][4];
    int   b_buf[4][4];
    int   fa[16][4];
    int   fb[16][4];
    int   acc[4][4];
    int   sp[4][4][4];
    int   sp_init[4][4][4];
    int   rdata[4];
    logic load_req = 1'b0;

    function automatic int cur_a(int i);
        if (feed_zero_o || feed_k_o >= 4) return 0;
        return a_buf[i][feed_k_o];
    endfunction

    function automatic int cur_b(int j);
        if (feed_zero_o || feed_k_o >= 4) return 0;
        return b_buf[feed_k_o][j];
    endfunction

    // PE(i,j) sees the slice injected i+j steps earlier.
    function automatic int mac(int i, int j);
        int s;
        s = int'(feed_k_o) - i - j;
        if (s < 0) return 0;
        if (s == int'(feed_k_o)) return cur_a(i) * cur_b(j);
        return fa[s][i] * fb[s][j];
    endfunction

    always @(posedge clk_i) begin
        if (load_req) sp <= sp_init;
        if (pe_clear_o)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) acc[i][j] <= 0;
        if (pe_valid_o) begin
            for (int i = 0; i < 4; i++) begin
                fa[feed_k_o][i] <= cur_a(i);
                fb[feed_k_o][i] <= cur_b(i);
            end
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) acc[i][j] <= acc[i][j] + mac(i, j);
        end
        if (sp_rd_en_o)
            for (int j = 0; j < 4; j++) rdata[j] <= sp[sp_addr_o[3:2]][sp_addr_o[1:0]][j];
        if (sp_wr_en_o)
            for (int j = 0; j < 4; j++)
                sp[sp_addr_o[3:2]][sp_addr_o[1:0]][j] <=
                    acc[sp_addr_o[1:0]][j] + (add_bias_o ? rdata[j] : 0);
    end

    typedef struct {
        logic [1:0] dn, dk, dm;
        logic       bias;
        logic [1:0] wt, rt;
        int done_cyc, n_valid, n_zero, n_wr, n_rd, first_wr, p1, p2;
    } vec_t;

    vec_t vecs[6];

    // Start pulse lands in cycle 0; cycle c is sampled at the negedge inside it.
    task automatic run_vec(input vec_t v, input string tag);
        int done_c = -1, clr_c = -1, nv = 0, nz = 0, nw = 0, nr = 0, fw = -1;
        int bad_busy = 0, bad_addr = 0, bad_k = 0;
        dim_n_i = v.dn; dim_k_i = v.dk; dim_m_i = v.dm;
        bias_en_i = v.bias; write_target_i = v.wt; read_target_i = v.rt;
        @(negedge clk_i);
        start_i = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            if (!busy_o) bad_busy++;
            if (pe_clear_o) clr_c = c;
            if (pe_valid_o) begin
                if (int'(feed_k_o) != nv) bad_k++;
                nv++;
                if (feed_zero_o) nz++;
            end
            if (sp_rd_en_o) begin
                if (sp_addr_o != {v.rt, 2'(nr)}) bad_addr++;
                nr++;
            end
            if (sp_wr_en_o) begin
                if (fw < 0) fw = c;
                if (sp_addr_o != {v.wt, 2'(nw)} || add_bias_o != v.bias ||
                    (v.bias && nr != nw + 1)) bad_addr++;
                nw++;
            end
            start_i = (c == v.p1 || c == v.p2);
            if (start_i) begin
                dim_n_i = 2'd0; dim_k_i = 2'd0; dim_m_i = 2'd0;
                bias_en_i = ~v.bias; write_target_i = ~v.wt; read_target_i = ~v.rt;
            end
            if (done_o) begin
                done_c = c;
                break;
            end
        end
        chk({tag, ".done_cycle"}, done_c, v.done_cyc);
        chk({tag, ".clear_cycle"}, clr_c, 1);
        chk({tag, ".valid_count"}, nv, v.n_valid);
        chk({tag, ".zero_count"}, nz, v.n_zero);
        chk({tag, ".feed_k_seq_errs"}, bad_k, 0);
        chk({tag, ".wr_count"}, nw, v.n_wr);
        chk({tag, ".rd_count"}, nr, v.n_rd);
        chk({tag, ".first_wr_cycle"}, fw, v.first_wr);
        chk({tag, ".addr_errs"}, bad_addr, 0);
        chk({tag, ".busy_low_cycles"}, bad_busy, 0);
        @(negedge clk_i);
        start_i = 1'b0;
        chk({tag, ".idle_after_done"}, int'(busy_o), 0);
        @(negedge clk_i);
        chk({tag, ".no_restart"}, int'(busy_o | pe_clear_o), 0);
    endtask

    task automatic golden(input int it);
        int n, k, m, rt, wt, exp, done_c;
        logic bias;
        n = $urandom_range(1, 4); k = $urandom_range(1, 4); m = $urandom_range(1, 4);
        bias = 1'($urandom_range(0, 1));
        rt = $urandom_range(0, 3); wt = $urandom_range(0, 3);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a_buf[i][j] = $urandom_range(0, 255);
                b_buf[i][j] = $urandom_range(0, 255);
                for (int t = 0; t < 4; t++) sp_init[t][i][j] = $urandom_range(0, 1000);
            end
        @(negedge clk_i);
        load_req = 1'b1;
        @(negedge clk_i);
        load_req = 1'b0;
        dim_n_i = 2'(n - 1); dim_k_i = 2'(k - 1); dim_m_i = 2'(m - 1);
        bias_en_i = bias; write_target_i = 2'(wt); read_target_i = 2'(rt);
        start_i = 1'b1;
        done_c = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (done_o) begin
                done_c = c;
                break;
            end
        end
        if (done_c < 0) chk($sformatf("golden%0d.timeout", it), 0, 1);
        for (int i = 0; i < 4; i++) begin
            if (i < n) begin
                for (int j = 0; j < m; j++) begin
                    exp = bias ? sp_init[rt][i][j] : 0;
                    for (int kk = 0; kk < k; kk++) exp += a_buf[i][kk] * b_buf[kk][j];
                    chk($sformatf("golden%0d.sp[%0d][%0d][%0d]", it, wt, i, j), sp[wt][i][j], exp);
                end
            end else begin
                for (int j = 0; j < 4; j++)
                    chk($sformatf("golden%0d.untouched[%0d][%0d]", it, i, j),
                        sp[wt][i][j], sp_init[wt][i][j]);
            end
        end
    endtask

    initial begin
        int wr_cnt;
        vecs[0] = '{2'd3, 2'd3, 2'd3, 1'b0, 2'd1, 2'd0, 17, 10, 6, 4, 0, 13, -1, -1};
        vecs[1] = '{2'd0, 2'd0, 2'd0, 1'b0, 2'd2, 2'd0,  5,  1, 0, 1, 0,  4, -1, -1};
        vecs[2] = '{2'd1, 2'd2, 2'd1, 1'b1, 2'd3, 2'd1, 12,  5, 2, 2, 2,  9, -1, -1};
        vecs[3] = '{2'd2, 2'd0, 2'd3, 1'b0, 2'd0, 2'd3, 12,  6, 5, 3, 0,  9, -1, -1};
        vecs[4] = '{2'd3, 2'd1, 2'd0, 1'b1, 2'd2, 2'd2, 16,  5, 3, 4, 4,  9, -1, -1};
        vecs[5] = '{2'd3, 2'd3, 2'd3, 1'b0, 2'd1, 2'd0, 17, 10, 6, 4, 0, 13,  5, 17};

        repeat (2) @(negedge clk_i);
        chk("reset_outputs", all_out(), 0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("idle_after_reset", all_out(), 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort a 4x4x4 run at cycle 8, then confirm a clean restart.
        dim_n_i = 2'd3; dim_k_i = 2'd3; dim_m_i = 2'd3;
        bias_en_i = 1'b0; write_target_i = 2'd1; read_target_i = 2'd0;
        @(negedge clk_i);
        start_i = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
        end
        #1 rst_ni = 1'b0;
        #1 chk("async_reset_outputs", all_out(), 0);
        wr_cnt = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (sp_wr_en_o || busy_o) wr_cnt++;
        end
        rst_ni = 1'b1;
        repeat (20) begin
            @(negedge clk_i);
            if (sp_wr_en_o || busy_o) wr_cnt++;
        end
        chk("no_activity_after_abort", wr_cnt, 0);
        run_vec(vecs[0], "post_reset");

        for (int it = 0; it < 20; it++) golden(it);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
